// File: rtl/bram_window_reader_pkg.sv
// Shared types and defaults for the BRAM window reader slice.
package bram_window_reader_pkg;

  localparam int DEF_VRES   = 480;
  localparam int DEF_HRES   = 640;
  localparam int DEF_NLINES = 8;
  localparam int DEF_PXW    = 9;

  // BRAM address width and the x / row counter width.
  localparam int ADDR_W = 13;
  localparam int XW     = 10;

  // Size of the ring with default geometry.
  localparam int FULL_BRAM = DEF_NLINES * DEF_HRES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPT,
    ST_PRESENT,
    ST_ACK,
    ST_REFILL,
    ST_EOF
  } state_t;

  // base + step, wrapped into [0, full). Only ever steps by one line, so one
  // conditional subtract is enough and no multiplier is needed.
  function automatic logic [ADDR_W-1:0] ring_add(input logic [ADDR_W-1:0] base,
                                                 input int step, input int full);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + (ADDR_W + 1)'(step);
    if (sum >= (ADDR_W + 1)'(full)) sum = sum - (ADDR_W + 1)'(full);
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/bram_window_reader_if.sv
// Column stream from the window reader to the downstream window filter.
interface bram_window_reader_if
  import bram_window_reader_pkg::*;
#(
  parameter int NLINES = DEF_NLINES,
  parameter int PXW    = DEF_PXW
);
  logic [NLINES*PXW-1:0] col_data;
  logic [XW-1:0]         col_x;
  logic [XW-1:0]         col_y;
  logic                  col_last;
  logic                  col_valid;
  logic                  col_ready;

  modport master (output col_data, col_x, col_y, col_last, col_valid, input col_ready);
  modport slave  (input col_data, col_x, col_y, col_last, col_valid, output col_ready);
endinterface

// File: rtl/bram_window_reader_addr_gen.sv
// Ring-buffer line base rotation: the oldest line's base (top) and the base
// of the lane currently being read, each advanced by one line with wrap.
module bram_ring_addr_gen
  import bram_window_reader_pkg::*;
#(
  parameter int HRES = DEF_HRES,
  parameter int FULL = FULL_BRAM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              top_clr,
  input  logic              top_adv,
  input  logic              lane_load,
  input  logic              lane_step,
  output logic [ADDR_W-1:0] lane_base
);

  logic [ADDR_W-1:0] top_base;

  // Rotate the top line on ack, reload/step the lane base during a column fetch.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (rst || top_clr) begin
      top_base  <= '0;
      lane_base <= '0;
    end else begin
      if (top_adv) top_base <= ring_add(top_base, HRES, FULL);
      if (lane_load)      lane_base <= top_base;
      else if (lane_step) lane_base <= ring_add(lane_base, HRES, FULL);
    end
  end

endmodule

// File: rtl/bram_window_reader.sv
// Scans the resident NLINES-tall window column by column and streams each
// column (oldest line in lane 0) downstream; hands lines back to the writer.
module bram_window_reader
  import bram_window_reader_pkg::*;
#(
  parameter int VRES   = DEF_VRES,
  parameter int HRES   = DEF_HRES,
  parameter int NLINES = DEF_NLINES,
  parameter int PXW    = DEF_PXW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wnd_in_bram,
  input  logic              pxconv_to_bram_wr_en,
  input  logic [15:0]       bram_to_rdr_data,
  output logic              rdr_to_bram_rd_en,
  output logic [ADDR_W-1:0] rdr_to_bram_addr,
  output logic              pixel_ack,
  output logic              busy,
  bram_window_reader_if.master col
);

  localparam int            LANE_W      = (NLINES > 1) ? $clog2(NLINES) : 1;
  localparam logic [XW-1:0] X_LAST      = XW'(HRES - 1);
  localparam logic [XW-1:0] Y_LAST      = XW'(VRES - NLINES);
  localparam logic [XW-1:0] REFILL_FULL = XW'(HRES);
  localparam logic [LANE_W-1:0] K_LAST  = LANE_W'(NLINES - 1);

  state_t            state;
  logic [XW-1:0]     x;
  logic [XW-1:0]     row_y;
  logic [XW-1:0]     refill_cnt;
  logic [XW-1:0]     refill_next;
  logic [LANE_W-1:0] k;       // lane whose read is being requested
  logic [LANE_W-1:0] rd_k;    // lane of the read on the BRAM port
  logic [LANE_W-1:0] cap_k;   // lane whose data is on bram_to_rdr_data
  logic              cap_en;
  logic              abort, start, accept, row_end, refill_done;
  logic              lane_load, lane_step, top_adv, top_clr;
  logic [ADDR_W-1:0] lane_base;
  logic              unused_hi;

  // Only the grey bits of the BRAM word are meaningful here.
  assign unused_hi = ^bram_to_rdr_data[15:PXW];

  assign busy      = (state != ST_IDLE);
  assign col.col_y = row_y;

  bram_ring_addr_gen #(
    .HRES (HRES),
    .FULL (NLINES * HRES)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .top_clr   (top_clr),
    .top_adv   (top_adv),
    .lane_load (lane_load),
    .lane_step (lane_step),
    .lane_base (lane_base)
  );

  // Per-cycle decisions shared by the FSM and the address generator.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    abort       = 1'b0;
    start       = 1'b0;
    accept      = 1'b0;
    row_end     = 1'b0;
    refill_next = refill_cnt + XW'(pxconv_to_bram_wr_en);
    refill_done = 1'b0;
    abort       = !wnd_in_bram && (state inside {ST_FETCH, ST_CAPT, ST_PRESENT, ST_ACK, ST_REFILL});
    start       = (state == ST_IDLE) && wnd_in_bram;
    accept      = (state == ST_PRESENT) && col.col_valid && col.col_ready;
    row_end     = (x == X_LAST);
    refill_done = (state == ST_REFILL) && (refill_next == REFILL_FULL);
    lane_load   = !abort && (start || (accept && !row_end) || refill_done);
    lane_step   = !abort && (state == ST_FETCH);
    top_adv     = !abort && (state == ST_ACK);
    top_clr     = abort || ((state == ST_EOF) && !wnd_in_bram);
  end

  // Main FSM: issues reads, captures lanes, runs the handshake and the refill wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      x                 <= '0;
      row_y             <= '0;
      refill_cnt        <= '0;
      k                 <= '0;
      rd_k              <= '0;
      cap_k             <= '0;
      cap_en            <= 1'b0;
      rdr_to_bram_rd_en <= 1'b0;
      rdr_to_bram_addr  <= '0;
      pixel_ack         <= 1'b0;
      col.col_data      <= '0;
      col.col_x         <= '0;
      col.col_last      <= 1'b0;
      col.col_valid     <= 1'b0;
    end else begin
      rdr_to_bram_rd_en <= 1'b0;
      pixel_ack         <= 1'b0;
      cap_en            <= rdr_to_bram_rd_en;
      cap_k             <= rd_k;

      // BRAM data for the read issued last cycle lands in its lane.
      if (cap_en && (state == ST_FETCH || state == ST_CAPT)) begin
        for (int l = 0; l < NLINES; l++) begin
          if (cap_k == LANE_W'(l)) col.col_data[l*PXW +: PXW] <= bram_to_rdr_data[PXW-1:0];
        end
      end

      case (state)
        ST_IDLE: begin
          if (wnd_in_bram) begin
            x     <= '0;
            k     <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rdr_to_bram_rd_en <= 1'b1;
          rdr_to_bram_addr  <= lane_base + ADDR_W'(x);
          rd_k              <= k;
          if (k == K_LAST) state <= ST_CAPT;
          else             k     <= k + 1'b1;
        end
        ST_CAPT: begin
          if (cap_en && cap_k == K_LAST) begin
            col.col_valid <= 1'b1;
            col.col_x     <= x;
            col.col_last  <= row_end;
            state         <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (accept) begin
            col.col_valid <= 1'b0;
            if (!row_end) begin
              x     <= x + 1'b1;
              k     <= '0;
              state <= ST_FETCH;
            end else if (row_y == Y_LAST) begin
              state <= ST_EOF;
            end else begin
              pixel_ack <= 1'b1;
              state     <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          row_y      <= row_y + 1'b1;
          x          <= '0;
          refill_cnt <= XW'(pxconv_to_bram_wr_en);
          state      <= ST_REFILL;
        end
        ST_REFILL: begin
          refill_cnt <= refill_next;
          if (refill_done) begin
            k     <= '0;
            state <= ST_FETCH;
          end
        end
        ST_EOF: begin
          if (!wnd_in_bram) begin
            row_y <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Frame restart from the writer: drop everything in flight.
      if (abort) begin
        state             <= ST_IDLE;
        col.col_valid     <= 1'b0;
        rdr_to_bram_rd_en <= 1'b0;
        pixel_ack         <= 1'b0;
        cap_en            <= 1'b0;
        row_y             <= '0;
        x                 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_window_reader.sv
// Directed bench for bram_window_reader with HRES=16, VRES=8, NLINES=4.
module tb_bram_window_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        wnd_in_bram;
  logic        wr_en;
  logic [15:0] bram_q;
  logic        rd_en;
  logic [12:0] addr;
  logic        pixel_ack;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int ack_count = 0;
  logic [12:0] rd_addr_q[$];

  bram_window_reader_if #(.NLINES(4), .PXW(9)) col_if ();

  bram_window_reader #(.VRES(8), .HRES(16), .NLINES(4), .PXW(9)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wnd_in_bram          (wnd_in_bram),
    .pxconv_to_bram_wr_en (wr_en),
    .bram_to_rdr_data     (bram_q),
    .rdr_to_bram_rd_en    (rd_en),
    .rdr_to_bram_addr     (addr),
    .pixel_ack            (pixel_ack),
    .busy                 (busy),
    .col                  (col_if)
  );

  always #5 clk = ~clk;

  // BRAM model: mem[a] = a mod 512 in the low bits, junk above that the reader must drop.
  always @(posedge clk) if (rd_en) bram_q <= {7'h55, addr[8:0]};

  // Log every read and every ack away from the active edge.
  always @(negedge clk) begin
    if (rd_en) rd_addr_q.push_back(addr);
    if (pixel_ack) ack_count++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] exp_col(input int y, input int x);
    logic [35:0] r;
    for (int k = 0; k < 4; k++) r[k*9 +: 9] = 9'(((y + k) % 4) * 16 + x);
    return r;
  endfunction

  // Advance until a column is valid; returns sampled in its first valid cycle.
  task automatic get_col(output logic [35:0] d, output logic [9:0] cx, output logic [9:0] cy,
                         output logic cl);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!col_if.col_valid && n < 60);
    check("col_valid_timeout", col_if.col_valid, 1'b1);
    d  = col_if.col_data;
    cx = col_if.col_x;
    cy = col_if.col_y;
    cl = col_if.col_last;
  endtask

  task automatic refill(input int n);
    wr_en = 1'b1;
    repeat (n) tick();
    wr_en = 1'b0;
  endtask

  task automatic scan_row(input int y, input int x0, input int x1, input int stall_x);
    logic [35:0] d, ds;
    logic [9:0]  cx, cy;
    logic        cl;
    int          rc0, rcs;
    bit          stable;
    for (int x = x0; x <= x1; x++) begin
      rc0 = rd_addr_q.size();
      if (x == stall_x) begin
        tick();
        col_if.col_ready = 1'b0;
      end
      get_col(d, cx, cy, cl);
      check("col_data", d, exp_col(y, x));
      check("col_x", cx, x);
      check("col_y", cy, y);
      check("col_last", cl, x == 15);
      if (rd_addr_q.size() > rc0) check("lane0_addr", rd_addr_q[rc0], (y % 4) * 16 + x);
      else check("lane0_read_missing", rd_addr_q.size(), rc0 + 1);
      if (x == stall_x) begin
        ds = col_if.col_data;
        rcs = rd_addr_q.size();
        stable = 1'b1;
        repeat (10) begin
          tick();
          if (!col_if.col_valid || col_if.col_data !== ds || col_if.col_x !== 10'(x)) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("bp_no_reads", rd_addr_q.size(), rcs);
        col_if.col_ready = 1'b1;
      end
    end
  endtask

  initial begin
    logic [35:0] d;
    logic [9:0]  cx, cy;
    logic        cl;
    int t, t_busy, rc;

    rst = 1'b1;
    wnd_in_bram = 1'b0;
    wr_en = 1'b0;
    col_if.col_ready = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_valid", col_if.col_valid, 1'b0);
    check("rst_data", col_if.col_data, 36'h0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_addr", addr, 13'h0);
    check("rst_ack", pixel_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_col_y", col_if.col_y, 10'h0);

    // First column and its latency from FETCH entry.
    rst = 1'b0;
    wnd_in_bram = 1'b1;
    t = 0;
    t_busy = -1;
    do begin
      tick();
      t++;
      if (busy && t_busy < 0) t_busy = t;
    end while (!col_if.col_valid && t < 40);
    check("first_latency", t - t_busy, 6);
    check("first_data", col_if.col_data, exp_col(0, 0));
    check("first_y", col_if.col_y, 10'd0);
    check("first_n_reads", rd_addr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (rd_addr_q.size() > i) check("first_addr", rd_addr_q[i], i * 16);

    // Rest of row 0 with a 10-cycle stall at x=5.
    scan_row(0, 1, 15, 5);

    // Row end: single-cycle ack, then hold until 16 strobes seen.
    tick();
    check("ack_high", pixel_ack, 1'b1);
    tick();
    check("ack_low", pixel_ack, 1'b0);
    rc = rd_addr_q.size();
    refill(15);
    repeat (4) tick();
    check("refill_hold", rd_addr_q.size(), rc);
    check("refill_busy", busy, 1'b1);
    refill(1);
    scan_row(1, 0, 15, -1);

    // Strobe on the accept edge is ignored, the one in the ACK cycle counts.
    rc = rd_addr_q.size();
    refill(16);
    repeat (4) tick();
    check("refill_ack_strobe_hold", rd_addr_q.size(), rc);
    refill(1);
    check("ack_count_2", ack_count, 2);

    // Abort during a FETCH of row 2.
    scan_row(2, 0, 1, -1);
    tick();
    wnd_in_bram = 1'b0;
    tick();
    tick();
    check("abort_valid", col_if.col_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_no_ack", ack_count, 2);

    // Full frame after restart, ending in EOF with no final ack.
    wnd_in_bram = 1'b1;
    for (int y = 0; y < 5; y++) begin
      scan_row(y, 0, 15, -1);
      if (y < 4) begin
        tick();
        tick();
        refill(16);
      end
    end
    rc = rd_addr_q.size();
    repeat (5) tick();
    check("eof_ack_count", ack_count, 6);
    check("eof_busy", busy, 1'b1);
    check("eof_no_reads", rd_addr_q.size(), rc);

    // Writer wraps the frame: reader returns to IDLE then restarts at row 0.
    wnd_in_bram = 1'b0;
    tick();
    tick();
    check("eof_idle", busy, 1'b0);
    wnd_in_bram = 1'b1;
    scan_row(0, 0, 2, -1);

    // Synchronous reset while a column is being presented.
    tick();
    col_if.col_ready = 1'b0;
    get_col(d, cx, cy, cl);
    check("pre_rst_x", cx, 10'd3);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", col_if.col_valid, 1'b0);
    check("mid_rst_data", col_if.col_data, 36'h0);
    check("mid_rst_x", col_if.col_x, 10'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", addr, 13'h0);
    rst = 1'b0;
    col_if.col_ready = 1'b1;
    scan_row(0, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
